// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-stage constants and FSM state type.
// Optional halt detection is enabled with FETCH_HALT_DETECT_EN.
package pc_fetch_stage_pkg;

  localparam int FETCH_PC_W    = 32;
  localparam int FETCH_INSTR_W = 32;

  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [FETCH_INSTR_W-1:0] HALT_OPCODE_D = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, flush and hold controls.
// Flush wins over load; neither asserted means hold.
module if_id_reg
  import pc_fetch_stage_pkg::*;
#(
  parameter int                 PC_W    = FETCH_PC_W,
  parameter int                 INSTR_W = FETCH_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP     = NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [PC_W-1:0]    i_pc4,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [PC_W-1:0]    o_pc4,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  // Bubble on flush, capture on load, otherwise keep contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pc4   <= '0;
      o_instr <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_pc4   <= '0;
      o_instr <= NOP;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_pc4   <= i_pc4;
      o_instr <= i_instr;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter, fetch FSM and IF/ID register.
// Define FETCH_HALT_DETECT_EN to stop fetch on HALT_OPCODE.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int                 PC_W        = FETCH_PC_W,
  parameter int                 INSTR_W     = FETCH_INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_D
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pc_mux_ctrl,
  input  logic [PC_W-1:0]    i_target_addr,
  input  logic               i_stall,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_ifid_pc4,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic               o_ifid_valid,
  output logic               o_halted
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target_aligned;
  logic            ifid_load;
  logic            ifid_flush;
  logic            unused_bits;

`ifdef FETCH_HALT_DETECT_EN
  fetch_state_e state_q;
  fetch_state_e state_d;
`endif

  assign pc_plus4       = pc_q + PC_W'(4);
  assign target_aligned = {i_target_addr[PC_W-1:2], 2'b00};

`ifdef FETCH_HALT_DETECT_EN
  assign unused_bits = ^i_target_addr[1:0];
`else
  assign unused_bits = ^{i_target_addr[1:0], HALT_OPCODE};
`endif

  // Next PC and IF/ID control: redirect > stall > halted > sequential.
  always_comb begin
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    state_d    = state_q;
`endif
    if (i_pc_mux_ctrl) begin
      pc_d       = target_aligned;
      ifid_flush = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
      state_d    = RUN;
`endif
    end else if (i_stall) begin
      pc_d = pc_q;
`ifdef FETCH_HALT_DETECT_EN
    end else if (state_q == HALTED) begin
      ifid_flush = 1'b1;
`endif
    end else begin
      ifid_load = 1'b1;
      pc_d      = pc_plus4;
`ifdef FETCH_HALT_DETECT_EN
      if (i_instr == HALT_OPCODE) begin
        pc_d    = pc_q;
        state_d = HALTED;
      end
`endif
    end
  end

  // PC register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef FETCH_HALT_DETECT_EN
  // Fetch FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign o_halted = (state_q == HALTED);
`else
  assign o_halted = 1'b0;
`endif

  assign o_pc = pc_q;

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP     (INSTR_W'(NOP_INSTR))
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ifid_load),
    .i_flush (ifid_flush),
    .i_pc4   (pc_plus4),
    .i_instr (i_instr),
    .o_pc4   (o_ifid_pc4),
    .o_instr (o_ifid_instr),
    .o_valid (o_ifid_valid)
  );

endmodule
